// File: rtl/comms_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line levels.
package comms_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_CLK_BAUD_RATIO = 25;

endpackage

// File: rtl/send_tx.sv
// Single-frame UART serialiser: start bit, DATA_SIZE bits LSB first, stop bit.
// Accepts a new trigger in the last cycle of its stop bit so frames can chain with no gap.
module tx
  import comms_pkg::*;
#(
  parameter int CLK_BAUD_RATIO = DEFAULT_CLK_BAUD_RATIO,
  parameter int DATA_SIZE      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 trigger_in,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int BAUD_W = $clog2(CLK_BAUD_RATIO);
  localparam int IDX_W  = $clog2(DATA_SIZE + 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_BAUD_RATIO - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_SIZE);
  localparam logic [IDX_W-1:0]  STOP_IDX  = IDX_W'(DATA_SIZE + 1);

  state_t                 state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_SIZE-1:0]   shreg;

  // Bit index 0 is the start bit, 1..DATA_SIZE the data, DATA_SIZE+1 the stop bit.
  assign busy_out = (state == SEND);
  assign done_out = (state == SEND) && (baud_cnt == BAUD_LAST) && (bit_idx == STOP_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      tx_out   <= LINE_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger_in) begin
            shreg    <= data_in;
            tx_out   <= START_BIT;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
              if (trigger_in) begin
                shreg   <= data_in;
                tx_out  <= START_BIT;
                bit_idx <= '0;
              end else begin
                tx_out <= LINE_IDLE;
                state  <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx < DATA_LAST) begin
                tx_out <= shreg[0];
                shreg  <= shreg >> 1;
              end else begin
                tx_out <= STOP_BIT;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/send.sv
// Multi-frame UART transmitter: latches a word and sends it as FRAMES back-to-back
// frames, least-significant frame first, reusing one tx serialiser.
module send
  import comms_pkg::*;
#(
  parameter int CLK_BAUD_RATIO = DEFAULT_CLK_BAUD_RATIO,
  parameter int FRAME_SIZE     = 8,
  parameter int FRAMES         = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         send_in,
  input  logic [FRAME_SIZE*FRAMES-1:0] data_in,
  output logic                         tx_out,
  output logic                         busy_out,
  output logic                         done_out
);

  localparam int DATA_SIZE = FRAME_SIZE * FRAMES;
  localparam int FRAME_W   = $clog2(FRAMES + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

  state_t                  state;
  logic [FRAME_W-1:0]      frame_idx;
  logic [DATA_SIZE-1:0]    word;
  logic                    tx_trigger;
  logic [FRAME_SIZE-1:0]   tx_data;
  logic                    tx_busy;
  logic                    tx_done;

  // First frame comes straight from data_in on the accept edge; later frames from
  // the word register, which is pre-shifted so the next frame always sits at the bottom.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tx_trigger = 1'b0;
    tx_data    = word[FRAME_SIZE-1:0];
    if (state == IDLE) begin
      tx_trigger = send_in;
      tx_data    = data_in[FRAME_SIZE-1:0];
    end else begin
      tx_trigger = tx_done && (frame_idx != FRAME_LAST);
    end
  end

  tx #(
    .CLK_BAUD_RATIO(CLK_BAUD_RATIO),
    .DATA_SIZE     (FRAME_SIZE)
  ) u_tx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .trigger_in(tx_trigger),
    .data_in   (tx_data),
    .tx_out    (tx_out),
    .busy_out  (tx_busy),
    .done_out  (tx_done)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      frame_idx <= '0;
      word      <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (send_in) begin
            word      <= data_in >> FRAME_SIZE;
            frame_idx <= '0;
            busy_out  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_busy && tx_done) begin
            if (frame_idx == FRAME_LAST) begin
              busy_out <= 1'b0;
              done_out <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_idx <= frame_idx + 1'b1;
              word      <= word >> FRAME_SIZE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_send.sv
// Bench for send: a line-waveform model plus a far-end frame decoder checked every
// cycle, with directed scenarios pinned by hand-computed values.
module tb_send;

  localparam int R  = 4;
  localparam int FS = 8;
  localparam int NF = 2;
  localparam int DS = FS * NF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          send_r = 1'b0;
  logic [DS-1:0] data = '0;
  logic          tx_line, busy, done;

  logic          send6 = 1'b0;
  logic [4:0]    data6 = '0;
  logic          tx6, busy6, done6;

  always #5 clk = ~clk;

  send #(.CLK_BAUD_RATIO(R), .FRAME_SIZE(FS), .FRAMES(NF)) dut (
    .clk_in(clk), .rst_in(rst), .send_in(send_r), .data_in(data),
    .tx_out(tx_line), .busy_out(busy), .done_out(done)
  );

  send #(.CLK_BAUD_RATIO(2), .FRAME_SIZE(5), .FRAMES(1)) dut6 (
    .clk_in(clk), .rst_in(rst), .send_in(send6), .data_in(data6),
    .tx_out(tx6), .busy_out(busy6), .done_out(done6)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_done   = 0;

  bit            line_q[$];
  logic [DS-1:0] rx_q[$];
  bit            exp_done;
  int            dec_p = -1;
  int            dec_frame = 0;
  logic [DS-1:0] dec_word = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected line for a whole word: each bit repeated R cycles, frames back to back.
  task automatic build(input logic [DS-1:0] w);
    for (int f = 0; f < NF; f++) begin
      for (int r = 0; r < R; r++) line_q.push_back(1'b0);
      for (int b = 0; b < FS; b++)
        for (int r = 0; r < R; r++) line_q.push_back(w[f*FS + b]);
      for (int r = 0; r < R; r++) line_q.push_back(1'b1);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        line_q.delete();
        dec_p     = -1;
        dec_frame = 0;
        dec_word  = '0;
      end else begin
        bit was_idle;
        was_idle = (line_q.size() == 0);
        exp_done = 1'b0;
        if (!was_idle) begin
          void'(line_q.pop_front());
          if (line_q.size() == 0) exp_done = 1'b1;
        end
        if (was_idle && send_r) build(data);
        #1;
        if (!rst) begin
          check("tx_line", tx_line, (line_q.size() > 0) ? line_q[0] : 1'b1);
          check("busy", busy, line_q.size() > 0);
          check("done", done, exp_done);
          if (done) n_done++;
          // Far-end decoder: samples mid-bit and reassembles words from the line.
          if (dec_p < 0) begin
            if (tx_line == 1'b0) dec_p = 0;
          end else begin
            dec_p++;
          end
          if (dec_p >= 0) begin
            int k;
            k = dec_p / R;
            if (dec_p % R == R / 2) begin
              if (k == 0) check("dec_start_bit", tx_line, 0);
              else if (k <= FS) dec_word[dec_frame*FS + k - 1] = tx_line;
              else check("dec_stop_bit", tx_line, 1);
            end
            if (dec_p == (FS + 2) * R - 1) begin
              dec_p = -1;
              dec_frame++;
              if (dec_frame == NF) begin
                rx_q.push_back(dec_word);
                dec_frame = 0;
                dec_word  = '0;
              end
            end
          end
        end
      end
    end
  end

  task automatic pulse_send(input logic [DS-1:0] w);
    @(negedge clk);
    data   = w;
    send_r = 1'b1;
    @(posedge clk);
    #1;
    send_r = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wait_idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_done(output int at);
    int k = 0;
    at = -1;
    while (k < 400) begin
      @(posedge clk);
      #1;
      k++;
      if (done) begin
        at = cyc;
        break;
      end
    end
    check("wait_done_timeout", at >= 0, 1);
  endtask

  task automatic expect_word(input string name, input logic [DS-1:0] w);
    check({name, "_count"}, rx_q.size() > 0, 1);
    if (rx_q.size() > 0) check(name, rx_q.pop_front(), w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:19] exp1;
    logic [0:19] got1;
    logic [0:6]  exp6;
    logic [0:6]  got6;
    int busy_cnt, done0, d1, d2;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_tx", tx_line, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: A53C -> start, 3C LSB first, stop, start, A5 LSB first, stop
    exp1 = 20'b0_00111100_1_0_10100101_1;
    busy_cnt = 0;
    pulse_send(16'hA53C);
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < R; c++) begin
        if (c == 2) got1[i] = tx_line;
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
      end
    end
    check("t1_bits", got1, exp1);
    check("t1_busy_cycles", busy_cnt, 80);
    check("t1_busy_end", busy, 0);
    check("t1_done_pulse", done, 1);
    @(posedge clk);
    #1;
    check("t1_done_single", done, 0);
    @(negedge clk);
    check("t1_done_count", n_done, 1);
    expect_word("t1_word", 16'hA53C);

    // 2: all-zero and all-one words reassemble at the far end
    pulse_send(16'h0000);
    wait_idle();
    pulse_send(16'hFFFF);
    wait_idle();
    expect_word("t2_word0", 16'h0000);
    expect_word("t2_word1", 16'hFFFF);
    check("t2_done_count", n_done, 3);

    // 3: send held high; second word accepted in the done cycle
    @(negedge clk);
    data   = 16'h1234;
    send_r = 1'b1;
    @(posedge clk);
    #1;
    data = 16'h5678;
    wait_done(d1);
    check("t3_busy_low_in_done", busy, 0);
    @(posedge clk);
    #1;
    check("t3_accept_after_done", busy, 1);
    check("t3_start_bit", tx_line, 0);
    send_r = 1'b0;
    wait_done(d2);
    check("t3_spacing", d2 - d1, 81);
    @(negedge clk);
    expect_word("t3_word0", 16'h1234);
    expect_word("t3_word1", 16'h5678);

    // 4: request while busy is ignored
    done0 = n_done;
    pulse_send(16'hBEEF);
    repeat (30) @(posedge clk);
    @(negedge clk);
    data   = 16'hDEAD;
    send_r = 1'b1;
    @(negedge clk);
    send_r = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    expect_word("t4_word", 16'hBEEF);
    check("t4_no_extra_word", rx_q.size(), 0);
    check("t4_done_count", n_done - done0, 1);

    // 5: async reset in frame 1 aborts the word
    done0 = n_done;
    pulse_send(16'h1357);
    repeat (50) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_tx_idle", tx_line, 1);
    check("t5_busy_clear", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_done", n_done - done0, 0);
    check("t5_no_word", rx_q.size(), 0);
    pulse_send(16'h0F0F);
    wait_idle();
    expect_word("t5_clean_word", 16'h0F0F);

    // 6: FRAMES=1, FRAME_SIZE=5, ratio 2, data 10110
    exp6 = 7'b0_01101_1;
    busy_cnt = 0;
    @(negedge clk);
    data6 = 5'b10110;
    send6 = 1'b1;
    @(posedge clk);
    #1;
    send6 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (c == 1) got6[i] = tx6;
        if (busy6) busy_cnt++;
        @(posedge clk);
        #1;
      end
    end
    check("t6_bits", got6, exp6);
    check("t6_busy_cycles", busy_cnt, 14);
    check("t6_busy_end", busy6, 0);
    check("t6_done_pulse", done6, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
